// File: rtl/cpa_pkg.sv
// Shared types and default sizing for counter_period_averager.
package cpa_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DISCARD = 2'd1,
    FILLING = 2'd2,
    LOCKED  = 2'd3
  } cpa_state_e;

  localparam int CPA_COUNTER_WIDTH = 32;
  localparam int CPA_LOG2_DEPTH    = 3;
  localparam int DEPTH             = 1 << CPA_LOG2_DEPTH;
  localparam int SUM_WIDTH         = CPA_COUNTER_WIDTH + CPA_LOG2_DEPTH;
  localparam int REJ_WIDTH         = 16;

endpackage

// File: rtl/counter_period_averager_if.sv
// Sample/control/result bundle between the trigger stage and the period averager.
interface counter_period_averager_if
  import cpa_pkg::*;
#(
  parameter int COUNTER_WIDTH = CPA_COUNTER_WIDTH,
  parameter int LOG2_DEPTH    = CPA_LOG2_DEPTH
);
  logic                     enable;
  logic                     flush;
  logic [COUNTER_WIDTH-1:0] sample_in;
  logic                     sample_strobe;
  logic [COUNTER_WIDTH-1:0] reference_counter;
  logic                     reference_valid;
  logic [LOG2_DEPTH:0]      fill_level;
  logic [REJ_WIDTH-1:0]     reject_count;

  modport master (
    output enable, flush, sample_in, sample_strobe,
    input  reference_counter, reference_valid, fill_level, reject_count
  );

  modport slave (
    input  enable, flush, sample_in, sample_strobe,
    output reference_counter, reference_valid, fill_level, reject_count
  );
endinterface

// File: rtl/cpa_ring_buffer.sv
// Circular sample store; old_data_o is the entry the next write will overwrite.
module cpa_ring_buffer #(
  parameter int WIDTH      = 32,
  parameter int LOG2_DEPTH = 3
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             clr_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] old_data_o
);
  localparam int DEPTH_L = 1 << LOG2_DEPTH;

  logic [WIDTH-1:0]      mem_q [DEPTH_L];
  logic [LOG2_DEPTH-1:0] wr_ptr_q;
  logic [LOG2_DEPTH-1:0] wr_addr;

  // A clear with a write restarts the window with this sample in slot 0.
  assign wr_addr    = clr_i ? '0 : wr_ptr_q;
  assign old_data_o = mem_q[wr_ptr_q];

  always_ff @(posedge clk) begin
    if (!aresetn)     wr_ptr_q <= '0;
    else if (clr_i)   wr_ptr_q <= wr_en_i ? LOG2_DEPTH'(1) : '0;
    else if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr] <= wr_data_i;
  end
endmodule

// File: rtl/counter_period_averager.sv
// Moving average of completed period counts with lock detection.
// Optional outlier rejection: define COUNTER_PERIOD_AVERAGER_OUTLIER_REJECT_EN.
module counter_period_averager
  import cpa_pkg::*;
#(
  parameter int COUNTER_WIDTH = CPA_COUNTER_WIDTH,
  parameter int LOG2_DEPTH    = CPA_LOG2_DEPTH,
  parameter int TOL_SHIFT     = 4,
  parameter int MAX_REJECTS   = 4
) (
  input logic                      clk,
  input logic                      aresetn,
  counter_period_averager_if.slave cpa_if
);
  localparam int WIN_DEPTH = 1 << LOG2_DEPTH;
  localparam int SUM_W     = COUNTER_WIDTH + LOG2_DEPTH;

  cpa_state_e               state_q;
  logic [SUM_W-1:0]         sum_q;
  logic [SUM_W-1:0]         sum_upd;
  logic [LOG2_DEPTH:0]      fill_q;
  logic [COUNTER_WIDTH-1:0] ref_q;
  logic                     valid_q;
  logic [COUNTER_WIDTH-1:0] old_sample;
  logic strobe_ok, fill_wr, lock_strobe, reject, relock, buf_wr, buf_clr;
  logic unused_bits;

  assign strobe_ok   = cpa_if.sample_strobe && !cpa_if.flush;
  assign fill_wr     = (state_q == FILLING) && strobe_ok;
  assign lock_strobe = (state_q == LOCKED) && strobe_ok;
  assign buf_wr      = aresetn && cpa_if.enable && (fill_wr || (lock_strobe && !reject) || relock);
  assign buf_clr     = !cpa_if.enable || (cpa_if.flush && state_q != IDLE) || relock;
  assign sum_upd     = sum_q + SUM_W'(cpa_if.sample_in) - SUM_W'(old_sample);
  assign unused_bits = ^sum_q[LOG2_DEPTH-1:0];

  cpa_ring_buffer #(
    .WIDTH      (COUNTER_WIDTH),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_ring (
    .clk        (clk),
    .aresetn    (aresetn),
    .clr_i      (buf_clr),
    .wr_en_i    (buf_wr),
    .wr_data_i  (cpa_if.sample_in),
    .old_data_o (old_sample)
  );

`ifdef COUNTER_PERIOD_AVERAGER_OUTLIER_REJECT_EN
  localparam int RUN_W = $clog2(MAX_REJECTS + 1);

  logic [COUNTER_WIDTH-1:0] diff;
  logic [COUNTER_WIDTH-1:0] tol;
  logic [RUN_W-1:0]         run_q;
  logic [REJ_WIDTH-1:0]     rej_q;

  assign diff = (cpa_if.sample_in >= ref_q) ? cpa_if.sample_in - ref_q
                                            : ref_q - cpa_if.sample_in;
  assign tol  = ref_q >> TOL_SHIFT;
  // Only judge against a published average; the first LOCKED cycle still shows the old one.
  assign reject = lock_strobe && valid_q && (diff > tol);
  assign relock = reject && (run_q == RUN_W'(MAX_REJECTS - 1));

  always_ff @(posedge clk) begin
    if (!aresetn || !cpa_if.enable) begin
      run_q <= '0;
      rej_q <= '0;
    end else begin
      if (cpa_if.flush && state_q != IDLE) run_q <= '0;
      else if (reject)                     run_q <= relock ? '0 : run_q + 1'b1;
      else if (lock_strobe)                run_q <= '0;
      if (reject && rej_q != '1) rej_q <= rej_q + 1'b1;
    end
  end

  assign cpa_if.reject_count = rej_q;
`else
  logic unused_cfg;
  assign reject              = 1'b0;
  assign relock              = 1'b0;
  assign cpa_if.reject_count = '0;
  assign unused_cfg          = ^{32'(TOL_SHIFT), 32'(MAX_REJECTS)};
`endif

  always_ff @(posedge clk) begin
    if (!aresetn || !cpa_if.enable) begin
      state_q <= IDLE;
      sum_q   <= '0;
      fill_q  <= '0;
      ref_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (state_q == LOCKED) ref_q <= sum_q[SUM_W-1:LOG2_DEPTH];
      if (cpa_if.flush && state_q != IDLE) begin
        state_q <= DISCARD;
        sum_q   <= '0;
        fill_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE:    state_q <= DISCARD;
          DISCARD: if (cpa_if.sample_strobe) state_q <= FILLING;
          FILLING: if (fill_wr) begin
            sum_q  <= sum_q + SUM_W'(cpa_if.sample_in);
            fill_q <= fill_q + 1'b1;
            if (fill_q == (LOG2_DEPTH + 1)'(WIN_DEPTH - 1)) state_q <= LOCKED;
          end
          LOCKED: if (relock) begin
            // The sample that forced relock is a whole period, so it seeds the new window.
            state_q <= FILLING;
            sum_q   <= SUM_W'(cpa_if.sample_in);
            fill_q  <= (LOG2_DEPTH + 1)'(1);
            valid_q <= 1'b0;
          end else begin
            valid_q <= 1'b1;
            if (lock_strobe && !reject) sum_q <= sum_upd;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign cpa_if.reference_counter = ref_q;
  assign cpa_if.reference_valid   = valid_q;
  assign cpa_if.fill_level        = fill_q;
endmodule

// File: tb/tb_counter_period_averager.sv
// Vector-table bench for counter_period_averager (window of 4, 32-bit samples).
module tb_counter_period_averager;
  localparam int CW = 32;
  localparam int L2 = 2;

  typedef struct {
    logic          en;
    logic          fl;
    logic          st;
    logic [CW-1:0] smp;
    logic [CW-1:0] e_ref;
    logic          e_val;
    logic [L2:0]   e_fill;
    logic [15:0]   e_rej;
  } vec_t;

  logic clk = 1'b0;
  logic aresetn;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  counter_period_averager_if #(.COUNTER_WIDTH(CW), .LOG2_DEPTH(L2)) bus ();

  counter_period_averager #(
    .COUNTER_WIDTH (CW),
    .LOG2_DEPTH    (L2),
    .TOL_SHIFT     (4),
    .MAX_REJECTS   (4)
  ) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .cpa_if  (bus)
  );

  function automatic vec_t mk(logic en, logic fl, logic st, logic [CW-1:0] smp,
                              logic [CW-1:0] e_ref, logic e_val, int e_fill, int e_rej);
    vec_t v;
    v.en = en; v.fl = fl; v.st = st; v.smp = smp;
    v.e_ref = e_ref; v.e_val = e_val; v.e_fill = (L2+1)'(e_fill); v.e_rej = 16'(e_rej);
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [CW-1:0] act, logic [CW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(vec_t v, int idx);
    vec_t e;
    @(negedge clk);
    bus.enable        = v.en;
    bus.flush         = v.fl;
    bus.sample_strobe = v.st;
    bus.sample_in     = v.smp;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard step %0d: got empty queue expected one entry", idx);
    end else begin
      e = exp_q.pop_front();
      chk("reference_counter", idx, bus.reference_counter, e.e_ref);
      chk("reference_valid",   idx, CW'(bus.reference_valid), CW'(e.e_val));
      chk("fill_level",        idx, CW'(bus.fill_level), CW'(e.e_fill));
      chk("reject_count",      idx, CW'(bus.reject_count), CW'(e.e_rej));
    end
  endtask

  initial begin
    aresetn           = 1'b0;
    bus.enable        = 1'b1;
    bus.flush         = 1'b0;
    bus.sample_strobe = 1'b1;
    bus.sample_in     = 32'd55;
    // Reset must dominate an active enable and strobe.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ref",   0, bus.reference_counter, '0);
    chk("rst_valid", 0, CW'(bus.reference_valid), '0);
    chk("rst_fill",  0, CW'(bus.fill_level), '0);
    chk("rst_rej",   0, CW'(bus.reject_count), '0);
    @(negedge clk);
    aresetn = 1'b1;

    // en fl st sample        ref          val fill rej
    tbl.push_back(mk(1, 0, 0, 0,            0,           0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 999,          0,           0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 1000,         0,           0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 1000,         0,           0, 2, 0));
    tbl.push_back(mk(1, 0, 1, 1000,         0,           0, 3, 0));
    tbl.push_back(mk(1, 0, 1, 1000,         0,           0, 4, 0));
    tbl.push_back(mk(1, 0, 0, 0,            1000,        1, 4, 0));
    tbl.push_back(mk(1, 0, 1, 1004,         1000,        1, 4, 0));
    tbl.push_back(mk(1, 0, 1, 1004,         1001,        1, 4, 0));
    tbl.push_back(mk(1, 0, 1, 1004,         1002,        1, 4, 0));
    tbl.push_back(mk(1, 0, 1, 1004,         1003,        1, 4, 0));
    tbl.push_back(mk(1, 0, 0, 0,            1004,        1, 4, 0));
    tbl.push_back(mk(1, 1, 1, 5000,         1004,        0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 7,            1004,        0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 10,           1004,        0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 20,           1004,        0, 2, 0));
    tbl.push_back(mk(1, 0, 1, 30,           1004,        0, 3, 0));
    tbl.push_back(mk(1, 0, 1, 40,           1004,        0, 4, 0));
    tbl.push_back(mk(1, 0, 1, 50,           25,          1, 4, 0));
    tbl.push_back(mk(1, 0, 0, 0,            35,          1, 4, 0));
    tbl.push_back(mk(1, 1, 0, 0,            35,          0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 1,            35,          0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 32'hFFFFFFFF, 35,          0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 32'hFFFFFFFF, 35,          0, 2, 0));
    tbl.push_back(mk(1, 0, 1, 32'hFFFFFFFF, 35,          0, 3, 0));
    tbl.push_back(mk(1, 0, 1, 32'hFFFFFFFF, 35,          0, 4, 0));
    tbl.push_back(mk(1, 0, 0, 0,            32'hFFFFFFFF, 1, 4, 0));
    tbl.push_back(mk(1, 0, 0, 0,            32'hFFFFFFFF, 1, 4, 0));
    tbl.push_back(mk(0, 0, 1, 1234,         0,           0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,            0,           0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 3,            0,           0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 500,          0,           0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0,           0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i + 1);

`ifdef COUNTER_PERIOD_AVERAGER_OUTLIER_REJECT_EN
    // Lock at 1000, one outlier, one good sample, then four 2000s force a relock.
    apply(mk(1, 0, 0, 0,    0,    0, 0, 0), 100);
    apply(mk(1, 0, 1, 1,    0,    0, 0, 0), 101);
    for (int i = 0; i < 4; i++) apply(mk(1, 0, 1, 1000, 0, 0, i + 1, 0), 102 + i);
    apply(mk(1, 0, 0, 0,    1000, 1, 4, 0), 106);
    apply(mk(1, 0, 1, 1100, 1000, 1, 4, 1), 107);
    apply(mk(1, 0, 0, 0,    1000, 1, 4, 1), 108);
    apply(mk(1, 0, 1, 1000, 1000, 1, 4, 1), 109);
    apply(mk(1, 0, 1, 2000, 1000, 1, 4, 2), 110);
    apply(mk(1, 0, 1, 2000, 1000, 1, 4, 3), 111);
    apply(mk(1, 0, 1, 2000, 1000, 1, 4, 4), 112);
    apply(mk(1, 0, 1, 2000, 1000, 0, 1, 5), 113);
    apply(mk(1, 0, 1, 2000, 1000, 0, 2, 5), 114);
    apply(mk(1, 0, 0, 0,    1000, 0, 2, 5), 115);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
